// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle iterative shifter, one bit position per clock.
//
// Modes (sel): 000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR,
//              11x pass-through (out = in, handled as amt = 0).
// Handshake: start is accepted in IDLE or DONE (back-to-back allowed); busy is
// high while shifting; done pulses for one cycle; out holds until next done.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   start  request pulse, ignored while busy
//   in     operand, latched on accept
//   sel    mode, latched on accept
//   amt    shift count 0..WIDTH-1, latched on accept
//   busy   high while in SHIFT
//   done   one-cycle completion pulse
//   out    result register
//   ovf    overflow flag, valid with done (only with SHIFT_OVF_EN)
//
// Optional feature macro: SHIFT_OVF_EN adds the ovf port and its logic.
// WIDTH must be a power of two and at least 2.

module shift_unit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef SHIFT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] SelLsl = 3'b000;
  localparam logic [2:0] SelLsr = 3'b001;
  localparam logic [2:0] SelAsl = 3'b010;
  localparam logic [2:0] SelAsr = 3'b011;
  localparam logic [2:0] SelRol = 3'b100;
  localparam logic [2:0] SelRor = 3'b101;

  localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [2:0]       r_sel;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;
  logic             w_pass;
  logic             w_last;

  // Accept in IDLE or DONE; anything arriving during SHIFT is dropped.
  assign w_accept = start && (r_state != StShift);
  assign w_pass   = (sel[2:1] == 2'b11) || (amt == '0);
  assign w_last   = (r_cnt == CntOne);

  // One-position step of the working register for the latched mode.
  always_comb begin
    w_shifted = r_work;
    case (r_sel)
      SelLsl, SelAsl: w_shifted = {r_work[WIDTH-2:0], 1'b0};
      SelLsr:         w_shifted = {1'b0, r_work[WIDTH-1:1]};
      SelAsr:         w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      SelRol:         w_shifted = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      SelRor:         w_shifted = {r_work[0], r_work[WIDTH-1:1]};
      default:        w_shifted = r_work;
    endcase
  end

`ifdef SHIFT_OVF_EN
  logic r_ovf;
  logic r_ovf_acc;
  logic w_step_ovf;

  // LSL: a 1 leaves the MSB. ASL: the sign bit is about to change.
  always_comb begin
    w_step_ovf = 1'b0;
    case (r_sel)
      SelLsl:  w_step_ovf = r_work[WIDTH-1];
      SelAsl:  w_step_ovf = r_work[WIDTH-1] ^ r_work[WIDTH-2];
      default: w_step_ovf = 1'b0;
    endcase
  end

  // Accumulate across steps, but only publish on the done edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_acc <= 1'b0;
    end else if (r_state == StShift) begin
      r_ovf_acc <= r_ovf_acc | w_step_ovf;
      if (w_last) begin
        r_ovf <= r_ovf_acc | w_step_ovf;
      end
    end else if (w_accept) begin
      r_ovf     <= 1'b0;
      r_ovf_acc <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        StShift: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - CntOne;
          if (w_last) begin
            r_out   <= w_shifted;
            r_state <= StDone;
          end
        end
        default: begin
          // StIdle and StDone behave identically apart from done.
          if (w_accept) begin
            r_work <= in;
            r_sel  <= sel;
            r_cnt  <= amt;
            if (w_pass) begin
              r_out   <= in;
              r_state <= StDone;
            end else begin
              r_state <= StShift;
            end
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == StShift);
  assign done = (r_state == StDone);
  assign out  = r_out;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH = 8): spec vectors from a
// table, hand sequences for handshake/reset corners, then random operations
// compared against an arithmetic reference model.

module tb_shift_unit_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [2:0] sel   = 3'b000;
  logic [2:0] amt   = 3'd0;
  logic       busy;
  logic       done;
  logic [7:0] dout;
`ifdef SHIFT_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(
    .WIDTH(8),
    .AMT_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in   (din),
    .sel  (sel),
    .amt  (amt),
    .busy (busy),
    .done (done),
    .out  (dout)
`ifdef SHIFT_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic [2:0] n;
    logic [7:0] e;
    logic       ov;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_amt(input logic [2:0] s, input logic [2:0] n);
    return (s[2:1] == 2'b11) ? 0 : int'(n);
  endfunction

  // Whole-shift result from plain arithmetic on widened values.
  function automatic logic [7:0] ref_out(input logic [7:0] a, input logic [2:0] s,
                                         input logic [2:0] n);
    int                 e;
    logic [15:0]        d;
    logic signed [15:0] sx;
    e  = eff_amt(s, n);
    sx = {{8{a[7]}}, a};
    case (s)
      3'b000, 3'b010: begin d = {8'h00, a} << e; return d[7:0]; end
      3'b001:         begin d = {8'h00, a} >> e; return d[7:0]; end
      3'b011:         begin sx = sx >>> e; d = sx; return d[7:0]; end
      3'b100:         begin d = {a, a} << e; return d[15:8]; end
      3'b101:         begin d = {a, a} >> e; return d[7:0]; end
      default:        return a;
    endcase
  endfunction

  // LSL: anything left above bit 7. ASL: result no longer fits signed 8-bit.
  function automatic logic ref_ovf(input logic [7:0] a, input logic [2:0] s,
                                   input logic [2:0] n);
    int                 e;
    logic [15:0]        d;
    logic signed [15:0] sx;
    e  = eff_amt(s, n);
    sx = {{8{a[7]}}, a};
    if (e == 0) return 1'b0;
    case (s)
      3'b000: begin d = {8'h00, a} << e; return d[15:8] != 8'h00; end
      3'b010: begin sx = sx <<< e; return (sx > 16'sd127) || (sx < -16'sd128); end
      default: return 1'b0;
    endcase
  endfunction

  // One full request: accept, wait for done, check latency/busy/out/ovf.
  task automatic do_op(input logic [7:0] a, input logic [2:0] s, input logic [2:0] n,
                       input logic [7:0] exp_out, input logic exp_ovf, input string tag);
    int cyc;
    int bcnt;
    int exp_lat;
    cyc     = 0;
    bcnt    = 0;
    exp_lat = eff_amt(s, n);
    start = 1'b1;
    din   = a;
    sel   = s;
    amt   = n;
    tick();
    start = 1'b0;
    // Inputs are free to change after the accepting edge.
    din   = 8'($urandom);
    sel   = 3'($urandom);
    amt   = 3'($urandom);
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy cycles"}, bcnt, exp_lat);
    check({tag, " out"}, dout, exp_out);
`ifdef SHIFT_OVF_EN
    check({tag, " ovf"}, ovf, exp_ovf);
`endif
    tick();
    check({tag, " done width"}, done, 1'b0);
  endtask

  initial begin
    int         e;
    int         ndone;
    int         first;
    int         cyc;
    logic [7:0] outv;
    logic [7:0] ra;
    logic [2:0] rs;
    logic [2:0] rn;

    vecs.push_back('{8'h96, 3'b001, 3'd3, 8'h12, 1'b0, "lsr3"});
    vecs.push_back('{8'h96, 3'b011, 3'd3, 8'hF2, 1'b0, "asr3"});
    vecs.push_back('{8'h96, 3'b100, 3'd3, 8'hB4, 1'b0, "rol3"});
    vecs.push_back('{8'h96, 3'b101, 3'd1, 8'h4B, 1'b0, "ror1"});
    vecs.push_back('{8'hA5, 3'b000, 3'd0, 8'hA5, 1'b0, "lsl0"});
    vecs.push_back('{8'hA5, 3'b110, 3'd5, 8'hA5, 1'b0, "pass110"});
    vecs.push_back('{8'h3C, 3'b111, 3'd7, 8'h3C, 1'b0, "pass111"});
    vecs.push_back('{8'h40, 3'b010, 3'd1, 8'h80, 1'b1, "asl_ovf"});
    vecs.push_back('{8'h40, 3'b000, 3'd1, 8'h80, 1'b0, "lsl_noovf"});
    vecs.push_back('{8'h81, 3'b000, 3'd1, 8'h02, 1'b1, "lsl_ovf"});

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset out", dout, 8'h00);
`ifdef SHIFT_OVF_EN
    check("reset ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].s, vecs[i].n, vecs[i].e, vecs[i].ov, vecs[i].tag);
    end

    // Start while busy is dropped: ROR 7 on 0x01, second start at k+2.
    start = 1'b1; din = 8'h01; sel = 3'b101; amt = 3'd7;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; din = 8'hFF; sel = 3'b000; amt = 3'd3;
    tick();
    start = 1'b0;
    ndone = 0;
    first = -1;
    outv  = 8'h00;
    for (e = 2; e <= 16; e++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = e;
          outv  = dout;
        end
      end
      tick();
    end
    check("busy-drop done count", ndone, 1);
    check("busy-drop done edge", first, 7);
    check("busy-drop out", outv, 8'h02);

    // Back-to-back: new start in the DONE cycle is accepted.
    start = 1'b1; din = 8'hF0; sel = 3'b001; amt = 3'd2;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b first latency", cyc, 2);
    check("b2b first out", dout, 8'h3C);
    start = 1'b1; din = 8'h81; sel = 3'b100; amt = 3'd1;
    tick();
    start = 1'b0;
    check("b2b accept busy", busy, 1'b1);
    check("b2b accept done", done, 1'b0);
    check("b2b held out", dout, 8'h3C);
    tick();
    check("b2b second done", done, 1'b1);
    check("b2b second out", dout, 8'h03);
    tick();

    // Reset mid-shift aborts with no later done.
    start = 1'b1; din = 8'h0F; sel = 3'b000; amt = 3'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-reset busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort out", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("post-abort activity", ndone, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rs = 3'($urandom);
      rn = 3'($urandom_range(0, 7));
      do_op(ra, rs, rn, ref_out(ra, rs, rn), ref_ovf(ra, rs, rn), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
